frame_buffer_ctrl: RTL and testbench

Double-buffered 16x16 monochrome frame store that sits directly upstream of the LED matrix scan driver. Game logic draws into a hidden back buffer with pixel or row writes and a hardware clear sweep. It then requests a swap. The swap is applied only on a frame boundary, so the driver never scans a half-drawn frame. The front buffer is presented as a flat 256-bit `framebuffer` bus consumed by the scan driver.

---
 rtl/frame_buffer_ctrl.sv | 96 +++++++++
 tb/tb_frame_buffer_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_ctrl.sv
// Double-buffered 16x16 monochrome frame store for the LED matrix scan driver.
// Drawing goes to the hidden back buffer; front/back exchange happens only on frame_sync.
module frame_buffer_ctrl #(
  parameter logic CLR_VAL = 1'b0
) (
  input  logic         system_clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [3:0]   wr_x,
  input  logic [3:0]   wr_y,
  input  logic         wr_val,
  input  logic         row_wr_en,
  input  logic [3:0]   row_wr_y,
  input  logic [15:0]  row_wr_data,
  input  logic         clear_req,
  input  logic         swap_req,
  input  logic         frame_sync,
  output logic         busy,
  output logic         swap_done,
  output logic [255:0] framebuffer
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SWAP_WAIT = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [255:0]   buf0, buf1;
  logic [255:0]   back, back_next;
  logic           front_sel, front_sel_next;
  logic [3:0]     cnt, cnt_next;
  logic           swap_done_next;

  assign back        = front_sel ? buf0 : buf1;
  assign framebuffer = front_sel ? buf1 : buf0;

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    back_next      = back;
    front_sel_next = front_sel;
    swap_done_next = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_next = CLEAR;
          cnt_next   = 4'd0;
        end else if (swap_req) begin
          state_next = SWAP_WAIT;
        end else if (row_wr_en) begin
          back_next[{row_wr_y, 4'h0} +: 16] = row_wr_data;
        end else if (wr_en) begin
          back_next[{wr_y, wr_x}] = wr_val;
        end
      end
      CLEAR: begin
        back_next[{cnt, 4'h0} +: 16] = {16{CLR_VAL}};
        cnt_next = cnt + 4'd1;
        if (cnt == 4'd15) state_next = IDLE;
      end
      SWAP_WAIT: begin
        // frame_sync is only honoured here; earlier pulses are not latched
        if (frame_sync) begin
          front_sel_next = ~front_sel;
          swap_done_next = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      front_sel <= 1'b0;
      busy      <= 1'b0;
      swap_done <= 1'b0;
      buf0      <= '0;
      buf1      <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      front_sel <= front_sel_next;
      busy      <= (state_next != IDLE);
      swap_done <= swap_done_next;
      // only the back register is ever written
      if (front_sel) buf0 <= back_next;
      else           buf1 <= back_next;
    end
  end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed self-checking bench for frame_buffer_ctrl.
module tb_frame_buffer_ctrl;

  logic         system_clk;
  logic         rst;
  logic         wr_en;
  logic [3:0]   wr_x;
  logic [3:0]   wr_y;
  logic         wr_val;
  logic         row_wr_en;
  logic [3:0]   row_wr_y;
  logic [15:0]  row_wr_data;
  logic         clear_req;
  logic         swap_req;
  logic         frame_sync;
  logic         busy;
  logic         swap_done;
  logic [255:0] framebuffer;

  int checks   = 0;
  int failures = 0;

  logic [255:0] exp_fb, frame_a, frame_b;

  frame_buffer_ctrl #(.CLR_VAL(1'b0)) dut (
    .system_clk (system_clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_val     (wr_val),
    .row_wr_en  (row_wr_en),
    .row_wr_y   (row_wr_y),
    .row_wr_data(row_wr_data),
    .clear_req  (clear_req),
    .swap_req   (swap_req),
    .frame_sync (frame_sync),
    .busy       (busy),
    .swap_done  (swap_done),
    .framebuffer(framebuffer)
  );

  initial system_clk = 1'b0;
  always #5 system_clk = ~system_clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge system_clk);
      #1;
    end
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    cyc(1);
    swap_req   = 1'b0;
    frame_sync = 1'b1;
    cyc(1);
    frame_sync = 1'b0;
  endtask

  task automatic do_clear();
    clear_req = 1'b1;
    cyc(1);
    clear_req = 1'b0;
    cyc(16);
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; wr_x = 0; wr_y = 0; wr_val = 0;
    row_wr_en = 0; row_wr_y = 0; row_wr_data = 0;
    clear_req = 0; swap_req = 0; frame_sync = 0;

    // reset asserted before any clock edge
    #3;
    chk("rst_fb", framebuffer, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_swap_done", swap_done, 1'b0);
    cyc(2);
    rst = 1'b0;

    // idle with frame_sync pulsing: nothing happens
    for (int i = 0; i < 20; i++) begin
      frame_sync = (i % 4 == 0);
      cyc(1);
      chk("idle_swap_done", swap_done, 1'b0);
    end
    frame_sync = 1'b0;
    chk("idle_fb", framebuffer, '0);
    chk("idle_busy", busy, 1'b0);

    // pixel write (3,2) then swap
    wr_en = 1; wr_x = 4'd3; wr_y = 4'd2; wr_val = 1;
    cyc(1);
    wr_en = 0;
    chk("pix_hidden", framebuffer, '0);
    swap_req = 1;
    cyc(1);
    swap_req = 0;
    chk("swapwait_busy", busy, 1'b1);
    cyc(3);
    chk("swapwait_fb", framebuffer, '0);
    chk("swapwait_done", swap_done, 1'b0);
    frame_sync = 1;
    cyc(1);
    frame_sync = 0;
    exp_fb = '0; exp_fb[35] = 1'b1;
    chk("pix_fb", framebuffer, exp_fb);
    chk("pix_swap_done", swap_done, 1'b1);
    chk("pix_busy", busy, 1'b0);
    cyc(1);
    chk("pix_swap_done_pulse", swap_done, 1'b0);

    // row write beats pixel write in the same cycle
    row_wr_en = 1; row_wr_y = 4'd15; row_wr_data = 16'hA5A5;
    wr_en = 1; wr_x = 4'd0; wr_y = 4'd0; wr_val = 1;
    cyc(1);
    row_wr_en = 0; wr_en = 0;
    do_swap();
    exp_fb = '0; exp_fb[255:240] = 16'hA5A5;
    chk("row_prio_fb", framebuffer, exp_fb);

    // fill back buffer (holds pixel 35) with ones, then clear sweep
    for (int y = 0; y < 16; y++) begin
      row_wr_en = 1; row_wr_y = 4'(y); row_wr_data = 16'hFFFF;
      cyc(1);
    end
    row_wr_en = 0;
    clear_req = 1;
    cyc(1);
    clear_req = 0;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("clr_busy_%0d", i), busy, 1'b1);
      if (i == 5) begin
        wr_en = 1; wr_x = 4'd7; wr_y = 4'd0; wr_val = 1;
      end
      cyc(1);
      wr_en = 0;
    end
    chk("clr_busy_end", busy, 1'b0);
    chk("clr_front_untouched", framebuffer, exp_fb);

    // swap_req coinciding with frame_sync waits for the next pulse
    swap_req = 1; frame_sync = 1;
    cyc(1);
    swap_req = 0; frame_sync = 0;
    chk("coinc_busy", busy, 1'b1);
    chk("coinc_done", swap_done, 1'b0);
    cyc(2);
    chk("coinc_fb_held", framebuffer, exp_fb);
    frame_sync = 1;
    cyc(1);
    frame_sync = 0;
    chk("clr_fb", framebuffer, '0);
    chk("clr_swap_done", swap_done, 1'b1);

    // double-buffer retention: A, B, then A again with no drawing
    do_clear();
    row_wr_en = 1; row_wr_y = 4'd4; row_wr_data = 16'h1234;
    cyc(1);
    row_wr_en = 0;
    wr_en = 1; wr_x = 4'd15; wr_y = 4'd9; wr_val = 1;
    cyc(1);
    wr_en = 0;
    frame_a = '0; frame_a[79:64] = 16'h1234; frame_a[159] = 1'b1;
    do_swap();
    chk("ret_frame_a", framebuffer, frame_a);
    row_wr_en = 1; row_wr_y = 4'd0; row_wr_data = 16'hBEEF;
    cyc(1);
    row_wr_en = 0;
    frame_b = '0; frame_b[15:0] = 16'hBEEF;
    do_swap();
    chk("ret_frame_b", framebuffer, frame_b);
    do_swap();
    chk("ret_frame_a_again", framebuffer, frame_a);

    // reset in SWAP_WAIT aborts the pending swap
    swap_req = 1;
    cyc(1);
    swap_req = 0;
    chk("rstwait_busy_pre", busy, 1'b1);
    #2;
    rst = 1;
    #1;
    chk("rstwait_fb", framebuffer, '0);
    chk("rstwait_busy", busy, 1'b0);
    cyc(1);
    rst = 0;
    frame_sync = 1;
    cyc(1);
    frame_sync = 0;
    chk("rstwait_no_done", swap_done, 1'b0);
    chk("rstwait_fb_after", framebuffer, '0);
    chk("rstwait_busy_after", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
